// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive framing blocks.
// No logic of its own; latency and backpressure do not apply.
// Contents: FSM state enum, parity mode constants, frame length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // Whole-frame duration in clock cycles, start bit through last stop bit.
    function automatic int unsigned uart_frame_len(
        input int unsigned clks_per_bit,
        input int unsigned data_bits,
        input int unsigned parity_mode,
        input int unsigned stop_bits
    );
        int unsigned p;
        p = (parity_mode != PARITY_NONE) ? 1 : 0;
        return clks_per_bit * (1 + data_bits + p + stop_bits);
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Word handshake and serial-side status bundle for the UART transmitter.
// Pure wiring, zero latency.
// Backpressure: tx_valid must be held by the source until tx_ready is seen.
// Ports: tx_data/tx_valid from source; tx_ready/tx_busy/tx_done/txd from transmitter.
interface uart_tx_frame_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 txd;

    // Source side (bench or upstream logic).
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  txd
    );

    // Transmitter side.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output txd
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter, counts 0..CLKS_PER_BIT-1 while en is high.
// Latency: tick is combinational from the count, high during the last cycle of each bit.
// Backpressure: none; en low holds the count at zero.
// Ports: clk, rst (sync, active-high), en, tick (terminal count), tick_pre (one cycle before).
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick,
    output logic tick_pre
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
        $error("uart_bit_timer: CLKS_PER_BIT must be in 2..65535");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = en && (cnt_q == CNT_LAST);
    // Look-ahead lets a client register a pulse that lands on the final cycle.
    assign tick_pre = en && (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// Latency: txd goes low the cycle after accept; frame is F cycles, next accept at F+1 earliest.
// Backpressure: tx_ready only in IDLE; tx_valid while not ready is ignored and must be held.
// Ports: clk, rst (sync, active-high), tx (slave modport: tx_data/tx_valid in; tx_ready/tx_busy/tx_done/txd out).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_frame_if.slave   tx
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam bit   HAS_PARITY = (PARITY_MODE != PARITY_NONE);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    uart_state_e          state_q,    state_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [IDX_W-1:0]     bit_idx_q,  bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 parity_q,   parity_d;
    logic                 txd_q,      txd_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_busy_q,  tx_busy_d;
    logic                 tx_done_q,  tx_done_d;

    logic bit_tick;
    logic bit_tick_pre;

    // Timer runs only inside a frame, so it sits at zero when a word is accepted.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q != IDLE),
        .tick     (bit_tick),
        .tick_pre (bit_tick_pre)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        parity_d   = parity_q;
        txd_d      = txd_q;
        tx_ready_d = tx_ready_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                txd_d      = 1'b1;
                tx_ready_d = 1'b1;
                tx_busy_d  = 1'b0;
                if (tx.tx_valid && tx_ready_q) begin
                    state_d    = START;
                    shift_d    = tx.tx_data;
                    // Parity is frozen from the accepted word; later tx_data changes are irrelevant.
                    parity_d   = (PARITY_MODE == PARITY_ODD) ? ~(^tx.tx_data) : (^tx.tx_data);
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    txd_d      = 1'b0;
                    tx_ready_d = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end

            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end

            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
                        if (HAS_PARITY) begin
                            state_d = PARITY;
                            txd_d   = parity_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        // shift_q[0] is on the wire now; shift_q[1] is the next bit.
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end

            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end

            STOP: begin
                txd_d = 1'b1;
                // Registered pulse must be set one cycle early to land on the last stop cycle.
                if (bit_tick_pre && (stop_idx_q == LAST_STOP)) begin
                    tx_done_d = 1'b1;
                end
                if (bit_tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        state_d    = IDLE;
                        tx_ready_d = 1'b1;
                        tx_busy_d  = 1'b0;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                txd_d      = 1'b1;
                tx_ready_d = 1'b1;
                tx_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            parity_q   <= parity_d;
            txd_q      <= txd_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx.txd      = txd_q;
    assign tx.tx_ready = tx_ready_q;
    assign tx.tx_busy  = tx_busy_q;
    assign tx.tx_done  = tx_done_q;

endmodule
